// File: rtl/writeback_commit_unit.sv
// Writeback commit: selects the stage result, writes scalars immediately and
// serialises 128-bit vector results into one register-file lane per cycle.
module writeback_commit_unit #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                       clock,
  input  logic                       async_reset,
  input  logic [31:0]                instruction_W,
  input  logic                       write_scalar_reg_W,
  input  logic                       write_vector_reg_W,
  input  logic [1:0]                 result_source_W,
  input  logic [5:0]                 rd_W,
  input  logic [LANES*LANE_W-1:0]    ALU_result_bus_W,
  input  logic [LANES*LANE_W-1:0]    read_data_bus_W,
  input  logic [31:0]                PC_plus_4_W,
  output logic                       scalar_we,
  output logic [4:0]                 scalar_waddr,
  output logic [LANE_W-1:0]          scalar_wdata,
  output logic                       vector_we,
  output logic [4:0]                 vector_waddr,
  output logic [$clog2(LANES)-1:0]   vector_lane,
  output logic [LANE_W-1:0]          vector_wdata,
  output logic                       wb_stall,
  output logic                       wb_conflict,
  output logic [31:0]                retired_count
);

  localparam int BUS_W     = LANES * LANE_W;
  localparam int LANE_BITS = $clog2(LANES);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic [BUS_W-1:0]     data_q, data_d;
  logic [4:0]           idx_q, idx_d;
  logic                 conflict_q, conflict_d;
  logic [31:0]          retired_q, retired_d;
  logic [BUS_W-1:0]     result;
  logic                 stall;

  // The register index is only five bits wide; the top bit of rd_W carries nothing here.
  logic unused_rd_msb;
  assign unused_rd_msb = rd_W[5];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    result = '0;
    unique case (result_source_W)
      2'b00:   result = ALU_result_bus_W;
      2'b01:   result = read_data_bus_W;
      2'b10:   result = BUS_W'(PC_plus_4_W);
      default: result = '0;
    endcase
  end

  assign stall = (state_q == IDLE) ? write_vector_reg_W : (lane_q != LAST_LANE);

  // NOTE: the latched vector data is a plain register, not a memory, so it is reset with the rest.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      conflict_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      lane_q     <= lane_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      conflict_q <= conflict_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    data_d     = data_q;
    idx_d      = idx_q;
    conflict_d = conflict_q;
    retired_d  = retired_q;
    if (!stall && instruction_W != 32'd0) retired_d = retired_q + 32'd1;
    unique case (state_q)
      IDLE: begin
        if (write_vector_reg_W) begin
          state_d = BUSY;
          lane_d  = '0;
          data_d  = result;
          idx_d   = rd_W[4:0];
          if (write_scalar_reg_W) conflict_d = 1'b1;
        end
      end
      BUSY: begin
        // The held instruction is ignored; the sequence always runs to the last lane.
        if (lane_q == LAST_LANE) begin
          state_d = IDLE;
          lane_d  = '0;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even the combinational ones.
  always_comb begin
    scalar_we     = 1'b0;
    scalar_waddr  = '0;
    scalar_wdata  = '0;
    vector_we     = 1'b0;
    vector_waddr  = '0;
    vector_lane   = '0;
    vector_wdata  = '0;
    wb_stall      = 1'b0;
    wb_conflict   = conflict_q;
    retired_count = retired_q;
    if (!async_reset) begin
      wb_stall = stall;
      if (state_q == IDLE) begin
        scalar_we    = write_scalar_reg_W && !write_vector_reg_W && (rd_W[4:0] != 5'd0);
        scalar_waddr = rd_W[4:0];
        scalar_wdata = result[LANE_W-1:0];
      end else begin
        vector_we    = 1'b1;
        vector_waddr = idx_q;
        vector_lane  = lane_q;
        vector_wdata = data_q[lane_q*LANE_W +: LANE_W];
      end
    end else begin
      wb_conflict   = 1'b0;
      retired_count = '0;
    end
  end

endmodule

// File: tb/tb_writeback_commit_unit.sv
// Scoreboard bench: stimulus queues expected register-file writes, a negedge
// monitor pops and compares each write the DUT presents.
module tb_writeback_commit_unit;

  logic         clock = 1'b0;
  logic         async_reset;
  logic [31:0]  instruction_W;
  logic         write_scalar_reg_W, write_vector_reg_W;
  logic [1:0]   result_source_W;
  logic [5:0]   rd_W;
  logic [127:0] ALU_result_bus_W, read_data_bus_W;
  logic [31:0]  PC_plus_4_W;
  logic         scalar_we, vector_we, wb_stall, wb_conflict;
  logic [4:0]   scalar_waddr, vector_waddr;
  logic [31:0]  scalar_wdata, vector_wdata, retired_count;
  logic [1:0]   vector_lane;

  writeback_commit_unit dut (
    .clock(clock), .async_reset(async_reset), .instruction_W(instruction_W),
    .write_scalar_reg_W(write_scalar_reg_W), .write_vector_reg_W(write_vector_reg_W),
    .result_source_W(result_source_W), .rd_W(rd_W),
    .ALU_result_bus_W(ALU_result_bus_W), .read_data_bus_W(read_data_bus_W),
    .PC_plus_4_W(PC_plus_4_W), .scalar_we(scalar_we), .scalar_waddr(scalar_waddr),
    .scalar_wdata(scalar_wdata), .vector_we(vector_we), .vector_waddr(vector_waddr),
    .vector_lane(vector_lane), .vector_wdata(vector_wdata), .wb_stall(wb_stall),
    .wb_conflict(wb_conflict), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        vec;
    logic [4:0]  addr;
    logic [1:0]  lane;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_act, mon_exp;
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!async_reset && (scalar_we || vector_we)) begin
      mon_act.vec  = vector_we;
      mon_act.addr = vector_we ? vector_waddr : scalar_waddr;
      mon_act.lane = vector_we ? vector_lane : 2'd0;
      mon_act.data = vector_we ? vector_wdata : scalar_wdata;
      if (scalar_we && vector_we) check("dual_write", {scalar_we, vector_we}, 2'b01);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got 0x%0h expected no write", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    instruction_W      = '0;
    write_scalar_reg_W = 1'b0;
    write_vector_reg_W = 1'b0;
    result_source_W    = 2'b00;
    rd_W               = '0;
    ALU_result_bus_W   = '0;
    read_data_bus_W    = '0;
    PC_plus_4_W        = '0;
  endtask

  task automatic scalar_op(input logic [5:0] rd, input logic [1:0] src,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic exp_we, input logic [31:0] exp_data);
    instruction_W      = 32'h0000_0033;
    write_scalar_reg_W = 1'b1;
    write_vector_reg_W = 1'b0;
    result_source_W    = src;
    rd_W               = rd;
    ALU_result_bus_W   = {96'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC, alu};
    read_data_bus_W    = {96'h1212_1212_3434_3434_5656_5656, 32'h7878_7878};
    PC_plus_4_W        = pc4;
    if (exp_we) exp_q.push_back('{1'b0, rd[4:0], 2'd0, exp_data});
    #3;
    check("scalar_stall", wb_stall, 0);
    check("scalar_we", scalar_we, exp_we);
    tick();
    idle_inputs();
  endtask

  task automatic vec_op(input logic both, input logic [5:0] rd, input logic [1:0] src,
                        input logic [127:0] bus);
    int stalls;
    stalls = 0;
    instruction_W      = 32'h0000_0057;
    write_scalar_reg_W = both;
    write_vector_reg_W = 1'b1;
    result_source_W    = src;
    rd_W               = rd;
    ALU_result_bus_W   = (src == 2'b00) ? bus : ~bus;
    read_data_bus_W    = (src == 2'b01) ? bus : ~bus;
    PC_plus_4_W        = 32'h0000_0200;
    for (int l = 0; l < 4; l++) exp_q.push_back('{1'b1, rd[4:0], 2'(l), bus[32*l +: 32]});
    #3;
    for (int c = 0; c < 10 && wb_stall; c++) begin
      stalls++;
      tick();
      #3;
    end
    check("vector_stall_cycles", stalls, 4);
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    async_reset        = 1'b1;
    write_scalar_reg_W = 1'b1;
    write_vector_reg_W = 1'b1;
    rd_W               = 6'd5;
    ALU_result_bus_W   = 128'h1;
    #3;
    check("reset_outputs",
          {scalar_we, scalar_waddr, scalar_wdata, vector_we, vector_waddr, vector_lane, wb_stall, wb_conflict},
          0);
    check("reset_vdata_count", {vector_wdata, retired_count}, 0);
    tick();
    tick();
    idle_inputs();
    async_reset = 1'b0;
    tick();

    scalar_op(6'd5, 2'b00, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("count_after_alu", retired_count, 1);
    scalar_op(6'd0, 2'b10, 32'h5555_5555, 32'h0000_0104, 1'b0, 32'h0);
    check("count_after_x0", retired_count, 2);
    scalar_op(6'h29, 2'b10, 32'h5555_5555, 32'h0000_0104, 1'b1, 32'h0000_0104);
    scalar_op(6'd1, 2'b11, 32'h5555_5555, 32'h0000_0104, 1'b1, 32'h0);
    scalar_op(6'd12, 2'b01, 32'h5555_5555, 32'h0000_0104, 1'b1, 32'h7878_7878);
    check("count_after_scalars", retired_count, 5);
    check("conflict_clear", wb_conflict, 0);

    vec_op(1'b0, 6'd3, 2'b01, 128'h44444444_33333333_22222222_11111111);
    check("count_after_vector", retired_count, 6);
    check("conflict_after_vector", wb_conflict, 0);

    vec_op(1'b1, 6'd7, 2'b00, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1);
    check("count_after_conflict", retired_count, 7);
    check("conflict_set", wb_conflict, 1);
    vec_op(1'b0, 6'd0, 2'b00, 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C);
    check("conflict_sticky", wb_conflict, 1);
    tick();
    check("bubble_not_counted", retired_count, 8);

    instruction_W      = 32'h0000_0057;
    write_vector_reg_W = 1'b1;
    rd_W               = 6'd2;
    ALU_result_bus_W   = 128'h99999999_88888888_77777777_66666666;
    exp_q.push_back('{1'b1, 5'd2, 2'd0, 32'h6666_6666});
    exp_q.push_back('{1'b1, 5'd2, 2'd1, 32'h7777_7777});
    tick();
    tick();
    @(negedge clock);
    #1;
    async_reset = 1'b1;
    idle_inputs();
    #1;
    check("midreset_outputs", {vector_we, wb_stall, wb_conflict, scalar_we, vector_wdata}, 0);
    check("midreset_count", retired_count, 0);
    tick();
    async_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      #2;
      check("post_reset_idle", {vector_we, wb_stall}, 0);
    end
    check("post_reset_count", retired_count, 0);
    scalar_op(6'd9, 2'b00, 32'h0BAD_F00D, 32'h0, 1'b1, 32'h0BAD_F00D);
    check("post_reset_scalar_count", retired_count, 1);

    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    check("preload", retired_count, 32'hFFFF_FFFF);
    scalar_op(6'd0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    check("count_wrap", retired_count, 0);

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_commit_unit.md
WRITEBACK_COMMIT_UNIT -- requirements
Module: writeback_commit_unit

Interface
REQ-001 Parameter LANES, default 4, number of 32-bit lanes in one 128-bit vector result.
REQ-002 Parameter LANE_W, default 32, width of one lane and of the scalar datapath.
REQ-003 clock  in  1  single clock for the block; all state updates on its rising edge.
REQ-004 async_reset  in  1  reset, asynchronous and active-high.
REQ-005 instruction_W  in  32  instruction in writeback; 0 marks a bubble.
REQ-006 write_scalar_reg_W  in  1  writeback-stage scalar register write request.
REQ-007 write_vector_reg_W  in  1  writeback-stage vector register write request.
REQ-008 result_source_W  in  2  result select: 00 ALU, 01 read data, 10 PC+4, 11 reserved.
REQ-009 rd_W  in  6  destination; bits [4:0] are the register index, bit 5 is ignored.
REQ-010 ALU_result_bus_W, read_data_bus_W  in  128 each  ALU and memory results.
REQ-011 PC_plus_4_W  in  32  return address for link instructions.
REQ-012 scalar_we / scalar_waddr / scalar_wdata  out  1/5/32  scalar register file write port.
REQ-013 vector_we / vector_waddr / vector_lane / vector_wdata  out  1/5/2/32  vector register file lane write port.
REQ-014 wb_stall  out  1  high means the writeback pipeline register enabler SHALL hold its contents.
REQ-015 wb_conflict  out  1  sticky flag: scalar and vector write requested together.
REQ-016 retired_count  out  32  count of retired non-bubble instructions.

Function
REQ-017 The result SHALL be selected as ALU_result_bus_W (00), read_data_bus_W (01), or {96'b0, PC_plus_4_W} (10); 11 SHALL yield 128'b0.
REQ-018 State machine states SHALL be IDLE and BUSY, with a 2-bit lane counter.
REQ-019 IDLE, write_vector_reg_W=0: scalar_we = write_scalar_reg_W and rd_W[4:0]!=0, scalar_waddr = rd_W[4:0], scalar_wdata = result[31:0], combinational, same cycle.
REQ-020 IDLE, write_vector_reg_W=1: wb_stall=1 combinationally; the edge latches result (128b) and rd_W[4:0], sets lane=0, and enters BUSY; scalar_we=0.
REQ-021 BUSY: vector_we=1, vector_waddr = latched index, vector_lane = lane, vector_wdata = latched[32*lane +: 32]; lane increments every cycle.
REQ-022 BUSY: wb_stall=1 while lane<3 and 0 at lane=3; at the lane-3 edge the state SHALL return to IDLE and lane SHALL wrap to 0.
REQ-023 BUSY SHALL ignore all writeback inputs, including the held vector instruction; scalar_we=0.
REQ-024 A vector write SHALL therefore occupy 5 cycles with 4 stall cycles; vector register 0 is writable.
REQ-025 write_scalar_reg_W and write_vector_reg_W both 1 in IDLE: the vector path wins, the scalar write is dropped, and wb_conflict SHALL set and stay set until reset.
REQ-026 retired_count SHALL increment by 1 on each edge where wb_stall=0 and instruction_W!=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 When idle, vector_we=0, vector_lane=0, and vector_waddr=0, vector_wdata=0.

Reset
REQ-028 async_reset=1 SHALL immediately force IDLE, lane=0, the latched data and index to 0, wb_conflict=0, and retired_count=0, independent of clock.
REQ-029 Reset during BUSY SHALL abandon the partial vector write; no further lanes are written after reset deasserts.
REQ-030 While reset is asserted, all outputs SHALL be 0, including wb_stall and scalar_we.

Verification
REQ-031 Scalar ALU write: rd=5, src=00, ALU[31:0]=0xDEADBEEF -> scalar_we=1, waddr=5, wdata=0xDEADBEEF in the same cycle, wb_stall=0, retired_count+1.
REQ-032 Scalar write to x0 with src=10, PC+4=0x104 -> scalar_we=0; retired_count still increments.
REQ-033 Vector write: rd=3, src=01, read_data=0x44444444_33333333_22222222_11111111 -> wb_stall high 4 cycles, then lanes 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on waddr=3, then IDLE; retired_count+1 once.
REQ-034 Both write flags set with rd=7 -> vector sequence only, no scalar write, wb_conflict=1 and stays 1.
REQ-035 Reset asserted after lane 1 of a vector write -> outputs 0 at once; after release no lanes 2/3 are written; state is IDLE and count=0.
REQ-036 Preload retired_count to 0xFFFFFFFF by force, then retire one instruction -> retired_count=0.
